// File: rtl/imem_dmem_responder_if.sv
// Bus bundle between the pipeline (master) and the memory responder (slave):
// fetch and data request/response handshakes plus the byte-wide image loader.
interface imem_dmem_responder_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [31:0] d_rsp_rdata;
  logic        d_rsp_err;

  logic        ld_valid;
  logic [11:0] ld_addr;
  logic [7:0]  ld_byte;

  modport master (
    output if_req_valid, if_addr, if_rsp_ready,
    output d_req_valid, d_req_we, d_addr, d_wdata, d_rsp_ready,
    output ld_valid, ld_addr, ld_byte,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );

  modport slave (
    input  if_req_valid, if_addr, if_rsp_ready,
    input  d_req_valid, d_req_we, d_addr, d_wdata, d_rsp_ready,
    input  ld_valid, ld_addr, ld_byte,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );
endinterface

// File: rtl/imem_dmem_responder.sv
// Big-endian byte-addressed program/data memory serving one fetch or load/store
// word access at a time, with a loader port that writes single bytes while idle.
module imem_dmem_responder #(
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 0
) (
  input logic                        clk,
  input logic                        rst_n,
  imem_dmem_responder_if.slave       bus
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESP_IF = 2'd2;
  localparam logic [1:0] S_RESP_D  = 2'd3;

  localparam logic [3:0]  WS_LAST   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  logic [7:0] mem [MEM_BYTES];

  logic [1:0]  state_q, state_d;
  logic        port_d_q, port_d_d;   // 1 = data port owns the access
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        idle_free;
  logic        grant_d, grant_if, ld_we;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_we, acc_port_d, acc_err;
  logic        perform, st_we;
  logic [1:0]  resp_state;
  logic [31:0] rd_word;

  // Operands come straight from the bus when the access completes in the
  // accepting cycle (no wait states), otherwise from the latched request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    idle_free  = rst_n && (state_q == S_IDLE) && !bus.ld_valid;
    ld_we      = rst_n && (state_q == S_IDLE) && bus.ld_valid;
    grant_d    = idle_free && bus.d_req_valid;
    grant_if   = idle_free && !bus.d_req_valid && bus.if_req_valid;

    acc_addr   = addr_q;
    acc_we     = we_q;
    acc_wdata  = wdata_q;
    acc_port_d = port_d_q;
    if (grant_d) begin
      acc_addr   = bus.d_addr;
      acc_we     = bus.d_req_we;
      acc_wdata  = bus.d_wdata;
      acc_port_d = 1'b1;
    end else if (grant_if) begin
      acc_addr   = bus.if_addr;
      acc_we     = 1'b0;
      acc_wdata  = 32'd0;
      acc_port_d = 1'b0;
    end

    acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr > LAST_WORD);
    resp_state = acc_port_d ? S_RESP_D : S_RESP_IF;
    perform    = ((grant_d || grant_if) && (WAIT_STATES == 0)) ||
                 ((state_q == S_WAIT) && (cnt_q == WS_LAST));
    st_we      = perform && acc_we && !acc_err;

    rd_word = {mem[{acc_addr[AW-1:2], 2'd0}], mem[{acc_addr[AW-1:2], 2'd1}],
               mem[{acc_addr[AW-1:2], 2'd2}], mem[{acc_addr[AW-1:2], 2'd3}]};

    state_d  = state_q;
    port_d_d = port_d_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (grant_d || grant_if) begin
          port_d_d = acc_port_d;
          we_d     = acc_we;
          addr_d   = acc_addr;
          wdata_d  = acc_wdata;
          cnt_d    = 4'd0;
          state_d  = (WAIT_STATES == 0) ? resp_state : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WS_LAST) state_d = resp_state;
      end
      S_RESP_IF: if (bus.if_rsp_ready) state_d = S_IDLE;
      S_RESP_D:  if (bus.d_rsp_ready)  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (perform) begin
      rdata_d = (acc_err || acc_we) ? 32'd0 : rd_word;
      err_d   = acc_err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      port_d_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_d_q <= port_d_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the image survives reset, so the array has no reset branch and maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[bus.ld_addr] <= bus.ld_byte;
    end else if (st_we) begin
      for (int i = 0; i < 4; i++)
        mem[{acc_addr[AW-1:2], 2'(i)}] <= acc_wdata[8*(3-i) +: 8];
    end
  end

  assign bus.if_req_ready = grant_if;
  assign bus.d_req_ready  = grant_d;
  assign bus.if_rsp_valid = (state_q == S_RESP_IF);
  assign bus.d_rsp_valid  = (state_q == S_RESP_D);
  assign bus.if_rsp_data  = (state_q == S_RESP_IF) ? rdata_q : 32'd0;
  assign bus.if_rsp_err   = (state_q == S_RESP_IF) && err_q;
  assign bus.d_rsp_rdata  = (state_q == S_RESP_D)  ? rdata_q : 32'd0;
  assign bus.d_rsp_err    = (state_q == S_RESP_D)  && err_q;

endmodule

// File: tb/tb_imem_dmem_responder.sv
// Scoreboard bench: directed requests push expected responses, a negedge monitor
// pops and compares on every response handshake. Second instance has 3 wait states.
module tb_imem_dmem_responder;
  localparam int BUDGET = 50;

  logic clk = 1'b0;
  logic rst_n, rst3_n;
  always #5 clk = ~clk;

  imem_dmem_responder_if b0 ();
  imem_dmem_responder_if b3 ();

  imem_dmem_responder #(.MEM_BYTES(4096), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n),  .bus(b0));
  imem_dmem_responder #(.MEM_BYTES(4096), .WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(b3));

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_if0[$];
  logic [32:0] exp_d0[$];
  logic [32:0] exp_d3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (b0.if_rsp_valid && b0.if_rsp_ready) begin
      if (exp_if0.size() == 0) begin
        checks++; failures++;
        $display("FAIL if_rsp_unexpected: got data 0x%08h with nothing expected", b0.if_rsp_data);
      end else begin
        e = exp_if0.pop_front();
        check("if_rsp_data", b0.if_rsp_data, e[31:0]);
        check("if_rsp_err", 32'(b0.if_rsp_err), 32'(e[32]));
      end
    end
    if (b0.d_rsp_valid && b0.d_rsp_ready) begin
      if (exp_d0.size() == 0) begin
        checks++; failures++;
        $display("FAIL d_rsp_unexpected: got data 0x%08h with nothing expected", b0.d_rsp_rdata);
      end else begin
        e = exp_d0.pop_front();
        check("d_rsp_rdata", b0.d_rsp_rdata, e[31:0]);
        check("d_rsp_err", 32'(b0.d_rsp_err), 32'(e[32]));
      end
    end
    if (b3.d_rsp_valid && b3.d_rsp_ready) begin
      if (exp_d3.size() == 0) begin
        checks++; failures++;
        $display("FAIL d3_rsp_unexpected: got data 0x%08h with nothing expected", b3.d_rsp_rdata);
      end else begin
        e = exp_d3.pop_front();
        check("d3_rsp_rdata", b3.d_rsp_rdata, e[31:0]);
        check("d3_rsp_err", 32'(b3.d_rsp_err), 32'(e[32]));
      end
    end
  end

  task automatic ld(input int u, input logic [11:0] a, input logic [7:0] b);
    if (u == 0) begin b0.ld_valid = 1'b1; b0.ld_addr = a; b0.ld_byte = b; end
    else        begin b3.ld_valid = 1'b1; b3.ld_addr = a; b3.ld_byte = b; end
    step();
    b0.ld_valid = 1'b0;
    b3.ld_valid = 1'b0;
  endtask

  // Issues one data request and returns #1 after the accepting edge.
  task automatic d_req(input int u, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic ee, input logic [31:0] er, input bit expect_rsp);
    bit acc = 1'b0;
    if (u == 0) begin
      b0.d_req_valid = 1'b1; b0.d_req_we = we; b0.d_addr = a; b0.d_wdata = wd;
      if (expect_rsp) exp_d0.push_back({ee, er});
    end else begin
      b3.d_req_valid = 1'b1; b3.d_req_we = we; b3.d_addr = a; b3.d_wdata = wd;
      if (expect_rsp) exp_d3.push_back({ee, er});
    end
    for (int i = 0; i < BUDGET && !acc; i++) begin
      @(negedge clk);
      acc = (u == 0) ? b0.d_req_ready : b3.d_req_ready;
    end
    check("d_req_accepted", 32'(acc), 32'd1);
    step();
    b0.d_req_valid = 1'b0;
    b3.d_req_valid = 1'b0;
  endtask

  task automatic f_req(input logic [31:0] a, input logic ee, input logic [31:0] er);
    bit acc = 1'b0;
    b0.if_req_valid = 1'b1; b0.if_addr = a;
    exp_if0.push_back({ee, er});
    for (int i = 0; i < BUDGET && !acc; i++) begin
      @(negedge clk);
      acc = b0.if_req_ready;
    end
    check("if_req_accepted", 32'(acc), 32'd1);
    step();
    b0.if_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_if0.size() + exp_d0.size() + exp_d3.size()) != 0 && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("rsp_within_budget", 32'(exp_if0.size() + exp_d0.size() + exp_d3.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.if_req_valid = 1'b0; b0.if_addr = '0; b0.if_rsp_ready = 1'b1;
    b0.d_req_valid = 1'b0; b0.d_req_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0; b0.d_rsp_ready = 1'b1;
    b0.ld_valid = 1'b0; b0.ld_addr = '0; b0.ld_byte = '0;
    b3.if_req_valid = 1'b0; b3.if_addr = '0; b3.if_rsp_ready = 1'b1;
    b3.d_req_valid = 1'b0; b3.d_req_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0; b3.d_rsp_ready = 1'b1;
    b3.ld_valid = 1'b0; b3.ld_addr = '0; b3.ld_byte = '0;

    // Reset state: requests pending yet nothing is granted or driven.
    rst_n = 1'b0; rst3_n = 1'b0;
    b0.if_req_valid = 1'b1; b0.d_req_valid = 1'b1; b0.d_addr = 32'h40;
    #12;
    check("rst_if_req_ready", 32'(b0.if_req_ready), 32'd0);
    check("rst_d_req_ready", 32'(b0.d_req_ready), 32'd0);
    check("rst_if_rsp_valid", 32'(b0.if_rsp_valid), 32'd0);
    check("rst_d_rsp_valid", 32'(b0.d_rsp_valid), 32'd0);
    check("rst_if_rsp_data", b0.if_rsp_data, 32'd0);
    check("rst_d_rsp_rdata", b0.d_rsp_rdata, 32'd0);
    check("rst_errs", 32'({b0.if_rsp_err, b0.d_rsp_err}), 32'd0);
    b0.if_req_valid = 1'b0; b0.d_req_valid = 1'b0;
    step();
    rst_n = 1'b1; rst3_n = 1'b1;
    step();

    // Loaded instruction word, zero-wait latency.
    ld(0, 12'h000, 8'h00); ld(0, 12'h001, 8'h22); ld(0, 12'h002, 8'h08); ld(0, 12'h003, 8'h00);
    f_req(32'h0, 1'b0, 32'h0022_0800);
    check("if_rsp_one_cycle", 32'(b0.if_rsp_valid), 32'd1);
    wait_idle();

    // Store/load round trip and big-endian byte placement.
    d_req(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    d_req(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    wait_idle();
    ld(0, 12'h041, 8'h55);
    d_req(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDE55_BEEF, 1'b1);
    wait_idle();

    // Loader outranks a pending data request.
    b0.ld_valid = 1'b1; b0.ld_addr = 12'h043; b0.ld_byte = 8'h77;
    b0.d_req_valid = 1'b1; b0.d_req_we = 1'b0; b0.d_addr = 32'h40;
    @(negedge clk);
    check("ld_blocks_d_ready", 32'(b0.d_req_ready), 32'd0);
    step();
    b0.ld_valid = 1'b0;
    d_req(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDE55_BE77, 1'b1);
    wait_idle();

    // Simultaneous fetch and data: data first, fetch after the data response.
    exp_d0.push_back({1'b0, 32'hDE55_BE77});
    exp_if0.push_back({1'b0, 32'h0022_0800});
    b0.d_req_valid = 1'b1; b0.d_req_we = 1'b0; b0.d_addr = 32'h40;
    b0.if_req_valid = 1'b1; b0.if_addr = 32'h0;
    @(negedge clk);
    check("arb_d_ready", 32'(b0.d_req_ready), 32'd1);
    check("arb_if_ready", 32'(b0.if_req_ready), 32'd0);
    step();
    b0.d_req_valid = 1'b0;
    @(negedge clk);
    check("arb_d_rsp_valid", 32'(b0.d_rsp_valid), 32'd1);
    check("arb_if_ready_busy", 32'(b0.if_req_ready), 32'd0);
    step();
    @(negedge clk);
    check("arb_if_ready_after", 32'(b0.if_req_ready), 32'd1);
    step();
    b0.if_req_valid = 1'b0;
    wait_idle();

    // Error cases and the top-of-memory boundary.
    d_req(0, 1'b0, 32'h42, 32'h0, 1'b1, 32'h0, 1'b1);
    f_req(32'h1000, 1'b1, 32'h0);
    d_req(0, 1'b1, 32'h41, 32'h1234_5678, 1'b1, 32'h0, 1'b1);
    d_req(0, 1'b1, 32'h8000_0040, 32'h1234_5678, 1'b1, 32'h0, 1'b1);
    d_req(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDE55_BE77, 1'b1);
    d_req(0, 1'b1, 32'hFFC, 32'hA5A5_0F0F, 1'b0, 32'h0, 1'b1);
    d_req(0, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'hA5A5_0F0F, 1'b1);
    d_req(0, 1'b0, 32'hFFD, 32'h0, 1'b1, 32'h0, 1'b1);
    d_req(0, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b1);
    f_req(32'hFFE, 1'b1, 32'h0);
    f_req(32'hFFC, 1'b0, 32'hA5A5_0F0F);
    wait_idle();

    // Response held under backpressure; fetch and loader ignored meanwhile.
    b0.d_rsp_ready = 1'b0;
    d_req(0, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'hA5A5_0F0F, 1'b1);
    b0.if_req_valid = 1'b1; b0.if_addr = 32'h0;
    b0.ld_valid = 1'b1; b0.ld_addr = 12'h040; b0.ld_byte = 8'h99;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_d_rsp_valid", 32'(b0.d_rsp_valid), 32'd1);
      check("hold_d_rsp_rdata", b0.d_rsp_rdata, 32'hA5A5_0F0F);
      check("hold_if_req_ready", 32'(b0.if_req_ready), 32'd0);
    end
    step();
    b0.ld_valid = 1'b0; b0.if_req_valid = 1'b0; b0.d_rsp_ready = 1'b1;
    wait_idle();
    d_req(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDE55_BE77, 1'b1);
    wait_idle();

    // Three wait states: response appears on the third edge after acceptance.
    ld(3, 12'h080, 8'h11); ld(3, 12'h081, 8'h22); ld(3, 12'h082, 8'h33); ld(3, 12'h083, 8'h44);
    d_req(3, 1'b0, 32'h80, 32'h0, 1'b0, 32'h1122_3344, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ws3_not_yet_valid", 32'(b3.d_rsp_valid), 32'd0);
    end
    @(negedge clk);
    check("ws3_valid", 32'(b3.d_rsp_valid), 32'd1);
    wait_idle();

    // Reset during a store's wait: outputs drop at once, store never lands.
    d_req(3, 1'b1, 32'h80, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    step();
    rst3_n = 1'b0;
    b3.d_req_valid = 1'b1; b3.d_req_we = 1'b0; b3.d_addr = 32'h80;
    #1;
    check("abort_d_req_ready", 32'(b3.d_req_ready), 32'd0);
    check("abort_if_req_ready", 32'(b3.if_req_ready), 32'd0);
    check("abort_d_rsp_valid", 32'(b3.d_rsp_valid), 32'd0);
    check("abort_d_rsp_rdata", b3.d_rsp_rdata, 32'd0);
    check("abort_d_rsp_err", 32'(b3.d_rsp_err), 32'd0);
    b3.d_req_valid = 1'b0;
    step();
    step();
    rst3_n = 1'b1;
    step();
    d_req(3, 1'b0, 32'h80, 32'h0, 1'b0, 32'h1122_3344, 1'b1);
    d_req(3, 1'b1, 32'h80, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1);
    d_req(3, 1'b0, 32'h80, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
